freelist: RTL and testbench

- Physical-register free list for the rename stage. It answers the two per-cycle allocation requests (`instr0_freelist_req`/`instr1_freelist_req`) with free physical register numbers.
- It accepts up to two released old_prd values per cycle from commit.
- On flush it restores the speculative allocation pointer to the architectural (committed) pointer.
- Implemented as a circular queue of preg indices with wrap-bit pointers.

---
 rtl/freelist.sv | 114 +++++++++++
 tb/tb_freelist.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/freelist.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | freelist : rename-stage physical register free list (circular queue)      |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module freelist #(
  parameter int NUM_PREG = 64,
  parameter int NUM_LREG = 32,
  parameter int DEPTH    = NUM_PREG - NUM_LREG,
  parameter int PTR_W    = $clog2(DEPTH) + 1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        instr0_freelist_req,
  output logic [$clog2(NUM_PREG)-1:0] instr0_freelist_resp,
  input  logic                        instr1_freelist_req,
  output logic [$clog2(NUM_PREG)-1:0] instr1_freelist_resp,
  output logic                        freelist_stall,
  input  logic                        commit0_valid,
  input  logic                        commit0_need_to_wb,
  input  logic [$clog2(NUM_PREG)-1:0] commit0_old_prd,
  input  logic                        commit1_valid,
  input  logic                        commit1_need_to_wb,
  input  logic [$clog2(NUM_PREG)-1:0] commit1_old_prd,
  input  logic                        flush_valid,
  output logic [PTR_W-1:0]            free_count
);

  localparam int PREG_W = $clog2(NUM_PREG);
  localparam int IDX_W  = PTR_W - 1;

  logic [PREG_W-1:0] queue_q [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  arch_head_q, arch_head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;

  logic              w_rel0, w_rel1;
  logic [1:0]        w_rel_cnt;
  logic [1:0]        w_req_cnt;
  logic [1:0]        w_alloc_cnt;
  logic [IDX_W-1:0]  w_head_idx1;
  logic [IDX_W-1:0]  w_tail_idx0, w_tail_idx1;
  logic [PTR_W:0]    w_fc_next;

  assign free_count     = tail_q - head_q;
  assign freelist_stall = (free_count < PTR_W'(2));

  assign w_head_idx1          = head_q[IDX_W-1:0] + IDX_W'(instr0_freelist_req);
  assign instr0_freelist_resp = queue_q[head_q[IDX_W-1:0]];
  assign instr1_freelist_resp = queue_q[w_head_idx1];

  assign w_rel0    = commit0_valid & commit0_need_to_wb;
  assign w_rel1    = commit1_valid & commit1_need_to_wb;
  assign w_rel_cnt = {1'b0, w_rel0} + {1'b0, w_rel1};

  assign w_tail_idx0 = tail_q[IDX_W-1:0];
  assign w_tail_idx1 = tail_q[IDX_W-1:0] + IDX_W'(w_rel0);

  // Requests are ignored on flush and clipped so head can never pass tail.
  always_comb begin
    w_req_cnt   = flush_valid ? 2'd0
                              : ({1'b0, instr0_freelist_req} + {1'b0, instr1_freelist_req});
    w_alloc_cnt = w_req_cnt;
    if (free_count < PTR_W'(w_req_cnt)) begin
      w_alloc_cnt = free_count[1:0];
    end
  end

  always_comb begin
    tail_d      = tail_q + PTR_W'(w_rel_cnt);
    arch_head_d = arch_head_q + PTR_W'(w_rel_cnt);
    head_d      = head_q + PTR_W'(w_alloc_cnt);
    if (flush_valid) begin
      head_d = arch_head_d;
    end
  end

  assign w_fc_next = {1'b0, free_count} - (PTR_W+1)'(w_alloc_cnt) + (PTR_W+1)'(w_rel_cnt);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_q      <= '0;
      arch_head_q <= '0;
      tail_q      <= {1'b1, {IDX_W{1'b0}}};
      for (int i = 0; i < DEPTH; i++) begin
        queue_q[i] <= PREG_W'(NUM_LREG + i);
      end
    end else begin
      head_q      <= head_d;
      arch_head_q <= arch_head_d;
      tail_q      <= tail_d;
      if (w_rel0) begin
        queue_q[w_tail_idx0] <= commit0_old_prd;
      end
      if (w_rel1) begin
        queue_q[w_tail_idx1] <= commit1_old_prd;
      end
    end
  end

`ifndef SYNTHESIS
  always @(posedge clock) begin
    if (!reset) begin
      assert (!(freelist_stall && !flush_valid && (instr0_freelist_req || instr1_freelist_req)))
        else $error("freelist: allocation request while stalled");
      assert (w_fc_next <= (PTR_W+1)'(DEPTH))
        else $error("freelist: release overflows the queue");
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_freelist.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_freelist : directed scoreboard bench for freelist                      |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_freelist;

  logic       clock = 1'b0;
  logic       reset;
  logic       instr0_freelist_req, instr1_freelist_req;
  logic [5:0] instr0_freelist_resp, instr1_freelist_resp;
  logic       freelist_stall;
  logic       commit0_valid, commit0_need_to_wb, commit1_valid, commit1_need_to_wb;
  logic [5:0] commit0_old_prd, commit1_old_prd;
  logic       flush_valid;
  logic [5:0] free_count;

  int checks = 0;
  int errors = 0;

  // Semantic model: avail = free pregs in allocation order,
  // spec = allocated but not yet committed pregs, oldest first.
  logic [5:0] avail[$];
  logic [5:0] spec[$];
  logic [5:0] exp0_q[$];
  logic [5:0] exp1_q[$];

  freelist dut (
    .clock                (clock),
    .reset                (reset),
    .instr0_freelist_req  (instr0_freelist_req),
    .instr0_freelist_resp (instr0_freelist_resp),
    .instr1_freelist_req  (instr1_freelist_req),
    .instr1_freelist_resp (instr1_freelist_resp),
    .freelist_stall       (freelist_stall),
    .commit0_valid        (commit0_valid),
    .commit0_need_to_wb   (commit0_need_to_wb),
    .commit0_old_prd      (commit0_old_prd),
    .commit1_valid        (commit1_valid),
    .commit1_need_to_wb   (commit1_need_to_wb),
    .commit1_old_prd      (commit1_old_prd),
    .flush_valid          (flush_valid),
    .free_count           (free_count)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic idle_inputs();
    instr0_freelist_req = 1'b0;
    instr1_freelist_req = 1'b0;
    commit0_valid = 1'b0; commit0_need_to_wb = 1'b0; commit0_old_prd = '0;
    commit1_valid = 1'b0; commit1_need_to_wb = 1'b0; commit1_old_prd = '0;
    flush_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    idle_inputs();
    reset = 1'b1;
    avail.delete();
    spec.delete();
    for (int i = 0; i < 32; i++) avail.push_back(6'(32 + i));
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic step(input logic r0, input logic r1,
                      input logic c0v, input logic c0wb, input logic [5:0] o0,
                      input logic c1v, input logic c1wb, input logic [5:0] o1,
                      input logic fl);
    bit p0, p1;
    @(negedge clock);
    instr0_freelist_req = r0;  instr1_freelist_req = r1;
    commit0_valid = c0v; commit0_need_to_wb = c0wb; commit0_old_prd = o0;
    commit1_valid = c1v; commit1_need_to_wb = c1wb; commit1_old_prd = o1;
    flush_valid = fl;
    p0 = (avail.size() > 0);
    p1 = r0 ? (avail.size() > 1) : (avail.size() > 0);
    if (p0) exp0_q.push_back(avail[0]);
    if (p1) exp1_q.push_back(r0 ? avail[1] : avail[0]);
    #1;
    if (p0) chk("resp0", 32'(instr0_freelist_resp), 32'(exp0_q.pop_front()));
    if (p1) chk("resp1", 32'(instr1_freelist_resp), 32'(exp1_q.pop_front()));
    if (!fl) begin
      if (r0) spec.push_back(avail.pop_front());
      if (r1) spec.push_back(avail.pop_front());
    end
    if (c0v && c0wb) begin
      if (spec.size() > 0) void'(spec.pop_front());
      avail.push_back(o0);
    end
    if (c1v && c1wb) begin
      if (spec.size() > 0) void'(spec.pop_front());
      avail.push_back(o1);
    end
    if (fl) begin
      while (spec.size() > 0) avail.push_front(spec.pop_back());
    end
    @(posedge clock);
    #1;
    chk("free_count", 32'(free_count), 32'(avail.size()));
    chk("stall", 32'(freelist_stall), 32'(avail.size() < 2));
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    #12;
    do_reset();
    #1;
    chk("rst_resp0", 32'(instr0_freelist_resp), 32);
    chk("rst_resp1", 32'(instr1_freelist_resp), 32);
    chk("rst_free_count", 32'(free_count), 32);
    chk("rst_stall", 32'(freelist_stall), 0);

    // Dual allocation after reset, then a single instr1 allocation.
    repeat (3) step(1, 1, 0, 0, 0, 0, 0, 0, 0);
    chk("fc_after_3_pairs", 32'(free_count), 26);
    step(0, 1, 0, 0, 0, 0, 0, 0, 0);

    // Drain to the stall threshold, release two, allocate across the wrap.
    do_reset();
    repeat (15) step(1, 1, 0, 0, 0, 0, 0, 0, 0);
    chk("fc_at_2", 32'(free_count), 2);
    chk("stall_at_2", 32'(freelist_stall), 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("stall_at_1", 32'(freelist_stall), 1);
    step(0, 0, 1, 1, 6'd5, 1, 1, 6'd9, 0);
    chk("fc_after_release", 32'(free_count), 3);
    #3;
    chk("wrap_resp0", 32'(instr0_freelist_resp), 63);
    step(1, 1, 0, 0, 0, 0, 0, 0, 0);

    // Commit then flush restores head to the architectural pointer.
    do_reset();
    repeat (2) step(1, 1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 1, 6'd7, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("fc_after_flush", 32'(free_count), 32);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (14) step(1, 1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0, 0, 0);
    chk("freed_at_tail", 32'(instr0_freelist_resp), 7);

    // Commit and flush in the same cycle, plus a non-writeback commit.
    do_reset();
    step(1, 1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 1, 6'd3, 0, 0, 0, 1);
    chk("fc_commit_flush", 32'(free_count), 32);
    step(1, 0, 1, 0, 6'd11, 0, 0, 0, 0);

    // Steady alloc/free pairs wrapping the queue several times.
    do_reset();
    for (int k = 1; k <= 40; k++) begin
      step(1, 1, 1, 1, 6'((2 * k - 1) % 64), 1, 1, 6'((2 * k) % 64), 0);
    end
    chk("fc_after_wrap", 32'(free_count), 32);

    // Asynchronous reset with requests in flight.
    repeat (3) step(1, 1, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clock);
    instr0_freelist_req = 1'b1;
    instr1_freelist_req = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    chk("async_fc", 32'(free_count), 32);
    chk("async_resp0", 32'(instr0_freelist_resp), 32);
    chk("async_resp1", 32'(instr1_freelist_resp), 33);
    do_reset();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
